// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, register indices and the
// major opcodes used by decode, write-back selection and the register file.
package riscv_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd2;

   localparam logic [XLEN-1:0] SP_RESET_DEFAULT = 32'h0000_3FFC;

   localparam logic [6:0] OP_LOAD   = 7'b000_0011;
   localparam logic [6:0] OP_JAL    = 7'b110_1111;
   localparam logic [6:0] OP_JALR   = 7'b110_0111;
   localparam logic [6:0] OP_OP     = 7'b011_0011;
   localparam logic [6:0] OP_OP_IMM = 7'b001_0011;

   // One-hot select of a register index, empty for x0 or when not enabled.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en,
                                                      input logic [REG_ADDR_W-1:0] idx);
      logic [NUM_REGS-1:0] oh;
      oh = {NUM_REGS{1'b0}};
      if (en && (idx != REG_ZERO)) begin
         oh[idx] = 1'b1;
      end else begin
         oh = {NUM_REGS{1'b0}};
      end
      return oh;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: tracks destinations of in-flight long-latency
// producers and asks decode to stall while a used source is still pending.
module reg_scoreboard
   import riscv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mark_valid,
   input  logic [REG_ADDR_W-1:0] mark_rd,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   output logic                  stall,
   output logic [NUM_REGS-1:0]   busy_mask
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] set_mask_s;
   logic [NUM_REGS-1:0] clr_mask_s;
   logic                rs1_wait_s;
   logic                rs2_wait_s;

   // Set is applied after clear so a newer producer keeps ownership of rd.
   always_comb begin
      set_mask_s = reg_onehot(mark_valid, mark_rd);
      clr_mask_s = reg_onehot(we, rd_addr);
      busy_d     = (busy_q & ~clr_mask_s) | set_mask_s;
      busy_d[0]  = 1'b0;
   end

   // Busy bit state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= {NUM_REGS{1'b0}};
      end else begin
         busy_q <= busy_d;
      end
   end

   // A write-back landing this cycle satisfies the source through the bypass.
   always_comb begin
      rs1_wait_s = 1'b0;
      rs2_wait_s = 1'b0;
      if (rs1_used && busy_q[rs1_addr] && !(we && (rd_addr == rs1_addr))) begin
         rs1_wait_s = 1'b1;
      end else begin
         rs1_wait_s = 1'b0;
      end
      if (rs2_used && busy_q[rs2_addr] && !(we && (rd_addr == rs2_addr))) begin
         rs2_wait_s = 1'b1;
      end else begin
         rs2_wait_s = 1'b0;
      end
   end

   assign stall     = rs1_wait_s | rs2_wait_s;
   assign busy_mask = busy_q;

endmodule

// File: rtl/reg_bank.sv
// Architectural integer register file x1..x31 with write-through bypass on
// both read ports and a pending-write scoreboard for long-latency producers.
module reg_bank
   import riscv_pkg::*;
#(
   parameter int unsigned     DATA_W   = XLEN,
   parameter logic [XLEN-1:0] SP_RESET = SP_RESET_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   output logic [DATA_W-1:0]     rs1_data,
   output logic [DATA_W-1:0]     rs2_data,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  mark_valid,
   input  logic [REG_ADDR_W-1:0] mark_rd,
   output logic                  stall,
   output logic [NUM_REGS-1:0]   busy_mask
);

   logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
   logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];
   logic [DATA_W-1:0]   rf_s   [0:NUM_REGS-1];
   logic [NUM_REGS-1:0] wr_sel_s;
   logic                byp1_s;
   logic                byp2_s;

   // Write decode; x0 never appears in the select so its writes vanish.
   always_comb begin
      wr_sel_s = reg_onehot(we, rd_addr);
      for (int i = 1; i < NUM_REGS; i++) begin
         if (wr_sel_s[i]) begin
            regs_d[i] = wdata;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Register storage; sp comes out of reset pointing at the stack top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= (i == int'(REG_SP)) ? DATA_W'(SP_RESET) : {DATA_W{1'b0}};
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Flat view with hardwired x0 so the read muxes index a full array.
   always_comb begin
      rf_s[0] = {DATA_W{1'b0}};
      for (int i = 1; i < NUM_REGS; i++) begin
         rf_s[i] = regs_q[i];
      end
   end

   assign byp1_s = we && (rd_addr == rs1_addr);
   assign byp2_s = we && (rd_addr == rs2_addr);

   // Read ports: x0 first, then same-cycle write-back, then storage.
   always_comb begin
      rs1_data = {DATA_W{1'b0}};
      rs2_data = {DATA_W{1'b0}};
      if (rs1_addr == REG_ZERO) begin
         rs1_data = {DATA_W{1'b0}};
      end else if (byp1_s) begin
         rs1_data = wdata;
      end else begin
         rs1_data = rf_s[rs1_addr];
      end
      if (rs2_addr == REG_ZERO) begin
         rs2_data = {DATA_W{1'b0}};
      end else if (byp2_s) begin
         rs2_data = wdata;
      end else begin
         rs2_data = rf_s[rs2_addr];
      end
   end

   reg_scoreboard u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .mark_valid (mark_valid),
      .mark_rd    (mark_rd),
      .we         (we),
      .rd_addr    (rd_addr),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_used   (rs1_used),
      .rs2_used   (rs2_used),
      .stall      (stall),
      .busy_mask  (busy_mask)
   );

endmodule
